// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix datapath: mod-3 residue type,
// frame-accumulator state encoding and the residue fold function.
package matrix_pkg;

    typedef logic [1:0] mod3_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } mod3_acc_state_e;

    // Shifts the running residue left by one word (times K = 2^WIDTH mod 3)
    // and adds the new word residue. Operands are legal residues 0..2.
    function automatic mod3_t mod3_fold(mod3_t acc, mod3_t m, bit k_is_two);
        mod3_t      scaled;
        logic [2:0] sum;
        if (k_is_two) begin
            case (acc)
                2'd1:    scaled = 2'd2;
                2'd2:    scaled = 2'd1;
                default: scaled = 2'd0;
            endcase
        end else begin
            scaled = acc;
        end
        sum = {1'b0, scaled} + {1'b0, m};
        return (sum >= 3'd3) ? mod3_t'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage

// File: rtl/syn_mod3_32.sv
// Combinational residue of one word (up to 32 bits) modulo 3.
module syn_mod3_32
    import matrix_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    output mod3_t            mod
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("syn_mod3_32: WIDTH must be in 1..32");
    end

    logic [31:0] padded;
    logic [5:0]  digit_sum;

    // Base-4 digits each carry weight 1 mod 3, so the digit sum (max 48)
    // has the same residue as the word.
    always_comb begin
        padded    = 32'(data);
        digit_sum = '0;
        // NOTE: blocking assignments in always_comb; digit_sum is a running
        // total within one evaluation, and assigning it first avoids a latch.
        for (int i = 0; i < 16; i++) begin
            digit_sum = digit_sum + 6'(padded[2*i +: 2]);
        end
        mod = mod3_t'(digit_sum % 6'd3);
    end

endmodule

// File: rtl/mod3_frame_accum.sv
// Folds per-word mod-3 residues of an MSW-first frame into a frame residue
// and presents it, with a saturating word count, over valid/ready.
module mod3_frame_accum
    import matrix_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               res_valid,
    input  logic               res_ready,
    output mod3_t              res_mod,
    output logic               res_zero,
    output logic [COUNT_W-1:0] res_count,
    output logic               res_ovf
);

    localparam bit K_IS_TWO = (WIDTH % 2) == 1;

    mod3_acc_state_e    state;
    mod3_t              acc;
    mod3_t              acc_next;
    mod3_t              word_mod;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cnt_next;
    logic               ovf;
    logic               ovf_next;
    logic               cnt_sat;
    logic               accept;

    syn_mod3_32 #(.WIDTH(WIDTH)) u_word_mod (
        .data (in_data),
        .mod  (word_mod)
    );

    // clr blocks acceptance in the same cycle so a coincident word is dropped.
    assign in_ready  = rst_n && !clr && (state != DONE);
    assign res_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        cnt_sat  = &cnt;
        cnt_next = cnt_sat ? cnt : cnt + COUNT_W'(1);
        ovf_next = ovf | cnt_sat;
        acc_next = mod3_fold(acc, word_mod, K_IS_TWO);
    end

    // NOTE: non-blocking assignments for all state so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            res_mod   <= '0;
            res_zero  <= 1'b0;
            res_count <= '0;
            res_ovf   <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt_next;
                        ovf <= ovf_next;
                        if (in_last) begin
                            state     <= DONE;
                            res_mod   <= acc_next;
                            res_zero  <= (acc_next == 2'd0);
                            res_count <= cnt_next;
                            res_ovf   <= ovf_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod3_frame_accum.sv
// Bench for mod3_frame_accum: two instances (WIDTH=8/COUNT_W=4 and
// WIDTH=5/COUNT_W=8) share stimulus and are checked against a frame-level model.
module tb_mod3_frame_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       res_ready;

    logic       a_in_ready, a_res_valid, a_res_zero, a_res_ovf;
    logic [1:0] a_res_mod;
    logic [3:0] a_res_count;
    logic       b_in_ready, b_res_valid, b_res_zero, b_res_ovf;
    logic [1:0] b_res_mod;
    logic [7:0] b_res_count;

    int total = 0;
    int bad   = 0;

    // Model: words of the open frame, and the pending result if any.
    int unsigned q[$];
    bit          pending;
    int          e8_mod, e8_cnt, e8_ovf;
    int          e5_mod, e5_cnt, e5_ovf;

    always #5 clk = ~clk;

    mod3_frame_accum #(.WIDTH(8), .COUNT_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (a_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .res_valid (a_res_valid),
        .res_ready (res_ready),
        .res_mod   (a_res_mod),
        .res_zero  (a_res_zero),
        .res_count (a_res_count),
        .res_ovf   (a_res_ovf)
    );

    mod3_frame_accum #(.WIDTH(5), .COUNT_W(8)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (b_in_ready),
        .in_data   (in_data[4:0]),
        .in_last   (in_last),
        .res_valid (b_res_valid),
        .res_ready (res_ready),
        .res_mod   (b_res_mod),
        .res_zero  (b_res_zero),
        .res_count (b_res_count),
        .res_ovf   (b_res_ovf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Frame value mod 3 computed directly from the word values.
    task automatic finish_frame();
        int r8 = 0;
        int r5 = 0;
        int n  = q.size();
        foreach (q[i]) begin
            r8 = (r8 * 256 + int'(q[i] & 8'hFF)) % 3;
            r5 = (r5 * 32 + int'(q[i] & 5'h1F)) % 3;
        end
        e8_mod = r8;
        e5_mod = r5;
        e8_cnt = (n > 15) ? 15 : n;
        e8_ovf = (n > 15) ? 1 : 0;
        e5_cnt = (n > 255) ? 255 : n;
        e5_ovf = (n > 255) ? 1 : 0;
        pending = 1'b1;
        q.delete();
    endtask

    task automatic compare_outputs();
        bit exp_ready = rst_n && !clr && !pending;
        check("a_in_ready", a_in_ready, exp_ready);
        check("b_in_ready", b_in_ready, exp_ready);
        check("a_res_valid", a_res_valid, pending);
        check("b_res_valid", b_res_valid, pending);
        if (pending) begin
            check("a_res_mod", a_res_mod, e8_mod);
            check("a_res_zero", a_res_zero, e8_mod == 0);
            check("a_res_count", a_res_count, e8_cnt);
            check("a_res_ovf", a_res_ovf, e8_ovf);
            check("b_res_mod", b_res_mod, e5_mod);
            check("b_res_zero", b_res_zero, e5_mod == 0);
            check("b_res_count", b_res_count, e5_cnt);
            check("b_res_ovf", b_res_ovf, e5_ovf);
        end
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step();
        if (clr) begin
            pending = 1'b0;
            q.delete();
        end else if (pending) begin
            if (res_ready) pending = 1'b0;
        end else if (in_valid) begin
            q.push_back(int'(in_data));
            if (in_last) finish_frame();
        end
    endtask

    task automatic cycle(input bit iv, input logic [7:0] dat, input bit il,
                         input bit ic, input bit irr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = dat;
        in_last   = il;
        clr       = ic;
        res_ready = irr;
        #1;
        compare_outputs();
        model_step();
    endtask

    initial begin
        rst_n = 1'b1;
        clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
        pending = 1'b0;
        #1 rst_n = 1'b0;
        in_valid = 1'b1;
        #2;
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        check("rst_a_res_valid", a_res_valid, 0);
        check("rst_a_res_mod", a_res_mod, 0);
        check("rst_a_res_count", a_res_count, 0);
        check("rst_a_res_ovf", a_res_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // {0x05, 0x07}: W8 value 1287 -> 0; W5 value 167 -> 2.
        cycle(1, 8'h05, 0, 0, 1);
        cycle(1, 8'h07, 1, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check("lit1_valid", a_res_valid, 1);
        check("lit1_a_mod", a_res_mod, 0);
        check("lit1_a_zero", a_res_zero, 1);
        check("lit1_a_count", a_res_count, 2);
        check("lit1_b_mod", b_res_mod, 2);

        // {0x01, 0x01}: W5 value 33 -> 0; W8 value 257 -> 2.
        cycle(1, 8'h01, 0, 0, 0);
        cycle(1, 8'h01, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        check("lit2_b_mod", b_res_mod, 0);
        check("lit2_a_mod", a_res_mod, 2);
        cycle(0, 8'h00, 0, 0, 1);

        // {0x01, 0x00}: W5 value 32 -> 2; W8 value 256 -> 1.
        cycle(1, 8'h01, 0, 0, 0);
        cycle(1, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        check("lit3_b_mod", b_res_mod, 2);
        check("lit3_a_mod", a_res_mod, 1);
        cycle(0, 8'h00, 0, 0, 1);

        // Single word 0x80, result held against a pushing source.
        cycle(1, 8'h80, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 1'($urandom), 0, 0);
        check("lit4_in_ready", a_in_ready, 0);
        check("lit4_a_mod", a_res_mod, 2);
        check("lit4_a_count", a_res_count, 1);
        check("lit4_b_mod", b_res_mod, 0);
        cycle(0, 8'h00, 0, 0, 1);
        cycle(1, 8'h01, 1, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check("lit5_a_mod", a_res_mod, 1);

        // 20 words of 0xFF: W8 saturates at 15.
        for (int i = 0; i < 20; i++) cycle(1, 8'hFF, i == 19, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        check("lit6_a_count", a_res_count, 15);
        check("lit6_a_ovf", a_res_ovf, 1);
        check("lit6_a_mod", a_res_mod, 0);
        check("lit6_b_count", b_res_count, 20);
        check("lit6_b_ovf", b_res_ovf, 0);
        check("lit6_b_mod", b_res_mod, 0);
        cycle(0, 8'h00, 0, 0, 1);

        // clr mid-frame with a coincident last word.
        for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0, 1);
        cycle(1, 8'h55, 1, 1, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check("lit7_no_result", a_res_valid, 0);
        cycle(1, 8'h02, 1, 0, 1);
        cycle(0, 8'h00, 0, 0, 1);
        check("lit8_a_mod", a_res_mod, 2);
        check("lit8_a_count", a_res_count, 1);
        check("lit8_b_mod", b_res_mod, 2);

        // Asynchronous reset while a result is pending.
        cycle(1, 8'h07, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst2_a_res_valid", a_res_valid, 0);
        check("rst2_b_res_valid", b_res_valid, 0);
        check("rst2_a_res_mod", a_res_mod, 0);
        check("rst2_a_res_zero", a_res_zero, 0);
        check("rst2_a_res_count", a_res_count, 0);
        check("rst2_a_in_ready", a_in_ready, 0);
        pending = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic, then long frames to reach count saturation.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(99) < 70, 8'($urandom), $urandom_range(99) < 25,
                  $urandom_range(99) < 3, $urandom_range(1));
        for (int i = 0; i < 1500; i++)
            cycle($urandom_range(99) < 85, 8'($urandom), $urandom_range(99) < 4,
                  $urandom_range(999) < 3, $urandom_range(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
